jk_flip_flop: RTL and testbench
===============================

// Module: jk_flip_flop
//
// PURPOSE
//   Clocked JK flip-flop bank: WIDTH independent JK storage cells sharing one clock and reset.
//   Each bit holds, clears, sets or toggles its state on the rising clock edge, selected by its J/K pair.
//   Used as a basic sequential primitive: counters, toggle registers and control flags.
//   Default WIDTH=1 gives the classic single-bit JK flip-flop.
//
// PARAMETERS
//   WIDTH      1    number of independent JK cells (>=1)
//   RST_VAL    '0   value loaded into q on reset (WIDTH bits)
//
// PORTS
//   clk    input   1      clock; all state changes on rising edge
//   rst    input   1      synchronous, active-high reset
//   j      input   WIDTH  per-bit J (set) input
//   k      input   WIDTH  per-bit K (reset) input
//   q      output  WIDTH  registered state
//   q_n    output  WIDTH  bitwise complement of q (combinational from q)
//   One clock; reset is synchronous and active-high.
//
// BEHAVIOUR
//   - All updates occur only at posedge clk; no asynchronous paths. j/k changes between edges have no effect on q.
//   - rst=1 at a posedge: q <= RST_VAL (default all zeros), q_n = ~RST_VAL. Reset overrides j/k.
//   - rst=0 at a posedge, per bit i, from the sampled j[i], k[i]:
//       j=0 k=0 -> hold      q[i] <= q[i]
//       j=0 k=1 -> clear     q[i] <= 0
//       j=1 k=0 -> set       q[i] <= 1
//       j=1 k=1 -> toggle    q[i] <= ~q[i]
//   - Latency: one cycle; q reflects the j/k sampled at the preceding posedge.
//   - Bits are fully independent; no carry or interaction between lanes.
//   - Power-up (before the first reset): q is X in simulation. Downstream logic must apply rst before relying on q.
//   - Reset asserted mid-sequence, e.g. during continuous toggling: q goes to RST_VAL at that edge.
//     Operation resumes from RST_VAL at the first edge with rst=0.
//   - q_n == ~q at all times after the first clock edge.
//   - X/Z on j or k with rst=0 propagates X to the affected q bit. No silent resolution.
//
// TESTING
//   - Reset: rst=1, j=1, k=1 for 2 edges -> q=0, q_n=1; toggle inputs ignored.
//   - Set/clear: rst=0; j=1,k=0 -> q=1 next edge; then j=0,k=1 -> q=0 next edge.
//   - Hold: q=1, then j=0,k=0 for 5 edges -> q stays 1; repeat from q=0 -> stays 0.
//   - Toggle: from q=0, j=1,k=1 for 4 edges -> q sequence 1,0,1,0 (divide-by-2 of clk).
//   - Reset mid-toggle: toggling with q=1, assert rst for one edge -> q=0; release with j=k=1 -> q=1 next edge.
//   - Mid-cycle glitch: pulse j between edges with k=0 -> q unchanged until the next posedge samples j.
//     WIDTH=4, j=4'b1010, k=4'b0110 from q=4'b0011 -> q=4'b1001 (per-bit toggle/set/clear/hold).

Source files
------------

// File: rtl/jk_flip_flop.sv
// Bank of WIDTH independent JK storage cells on a shared clock and synchronous reset.
// Each bit holds, clears, sets or toggles on the rising edge according to its own J/K pair.
module jk_flip_flop #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RST_VAL;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                // Unknown J/K falls to default so X reaches q instead of being resolved.
                case ({j[i], k[i]})
                    2'b00:   q[i] <= q[i];
                    2'b01:   q[i] <= 1'b0;
                    2'b10:   q[i] <= 1'b1;
                    2'b11:   q[i] <= ~q[i];
                    default: q[i] <= 1'bx;
                endcase
            end
        end
    end

    assign q_n = ~q;

endmodule

// File: tb/tb_jk_flip_flop.sv
// Scoreboard bench for a 4-lane JK flip-flop bank: expected q pushed at drive time,
// popped and compared one edge later.
module tb_jk_flip_flop;

    localparam int W = 4;
    localparam logic [W-1:0] RV = 4'b0000;

    logic         clk;
    logic         rst;
    logic [W-1:0] j;
    logic [W-1:0] k;
    logic [W-1:0] q;
    logic [W-1:0] q_n;

    logic [W-1:0] model_q;
    logic [W-1:0] exp_q[$];
    int           n_cmp;
    int           n_err;

    jk_flip_flop #(.WIDTH(W), .RST_VAL(RV)) dut (
        .clk (clk),
        .rst (rst),
        .j   (j),
        .k   (k),
        .q   (q),
        .q_n (q_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, want %b", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] jk_next(input logic [W-1:0] cur, input logic [W-1:0] jv,
                                             input logic [W-1:0] kv, input logic rv);
        logic [W-1:0] nxt;
        if (rv) return RV;
        for (int b = 0; b < W; b++) begin
            if (jv[b] && kv[b])      nxt[b] = ~cur[b];
            else if (jv[b])          nxt[b] = 1'b1;
            else if (kv[b])          nxt[b] = 1'b0;
            else                     nxt[b] = cur[b];
        end
        return nxt;
    endfunction

    // Drive at the falling edge, capture one rising edge later.
    task automatic step(input string tag, input logic rv, input logic [W-1:0] jv, input logic [W-1:0] kv);
        logic [W-1:0] e;
        rst = rv;
        j   = jv;
        k   = kv;
        model_q = jk_next(model_q, jv, kv, rv);
        exp_q.push_back(model_q);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check({tag, ".q"}, q, e);
        check({tag, ".q_n"}, q_n, ~e);
        @(negedge clk);
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        model_q = 'x;
        rst = 1'b1;
        j   = '1;
        k   = '1;

        step("rst0", 1'b1, 4'hF, 4'hF);
        step("rst1", 1'b1, 4'hF, 4'hF);

        step("set",   1'b0, 4'hF, 4'h0);
        step("clear", 1'b0, 4'h0, 4'hF);

        step("set_h", 1'b0, 4'hF, 4'h0);
        for (int i = 0; i < 5; i++) step("hold1", 1'b0, 4'h0, 4'h0);
        step("clr_h", 1'b0, 4'h0, 4'hF);
        for (int i = 0; i < 5; i++) step("hold0", 1'b0, 4'h0, 4'h0);

        for (int i = 0; i < 4; i++) step("toggle", 1'b0, 4'hF, 4'hF);

        step("tog_a",   1'b0, 4'hF, 4'hF);
        step("rst_mid", 1'b1, 4'hF, 4'hF);
        step("resume",  1'b0, 4'hF, 4'hF);

        // Mid-cycle j pulse must not disturb q before the next rising edge.
        step("pre_glitch", 1'b0, 4'h0, 4'hF);
        @(posedge clk);
        #2;
        j = 4'hF;
        k = 4'h0;
        #2;
        check("glitch_hi", q, model_q);
        j = 4'h0;
        #1;
        check("glitch_lo", q, model_q);
        @(negedge clk);
        exp_q.push_back(model_q);
        @(posedge clk);
        #1;
        check("glitch_edge", q, exp_q.pop_front());
        @(negedge clk);

        step("lanes_init", 1'b0, 4'b0011, 4'b1100);
        check("lanes_init_c", q, 4'b0011);
        step("lanes", 1'b0, 4'b1010, 4'b0110);
        check("lanes_c", q, 4'b1001);

        for (int i = 0; i < 24; i++) begin
            step("rand", ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0,
                 W'($urandom_range(0, 15)), W'($urandom_range(0, 15)));
        end

        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_drain: got %0d left, want 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
